// File: rtl/sad_pkg.sv
// Shared definitions for the SAD pipeline: default beat geometry and the
// occupancy state encoding used by every flow-controlled SAD stage.
package sad_pkg;

    localparam int SAD_LANES  = 4;
    localparam int SAD_DATA_W = 14;
    localparam int SAD_IDX_W  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } sad_state_e;

endpackage

// File: rtl/sad_pipe_stage.sv
// Valid/ready pipeline stage with a one-entry skid buffer between SAD tree stages.
// Optional saturating stall counter enabled by defining SAD_PIPE_STALL_CNT_EN.
module sad_pipe_stage
    import sad_pkg::*;
#(
    parameter int LANES  = SAD_LANES,
    parameter int DATA_W = SAD_DATA_W,
    parameter int IDX_W  = SAD_IDX_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IDX_W-1:0]        in_index,
    input  logic                    in_trigger,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        out_index,
    output logic                    out_trigger,
`ifdef SAD_PIPE_STALL_CNT_EN
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [15:0]             stall_cnt
`else
    output logic [LANES*DATA_W-1:0] out_data
`endif
);

    localparam int BEAT_W = IDX_W + 1 + LANES*DATA_W;

    sad_state_e        state_q, state_d;
    logic [BEAT_W-1:0] main_q, main_d;
    logic [BEAT_W-1:0] skid_q, skid_d;
    logic              out_valid_q, in_ready_q;
    logic [BEAT_W-1:0] in_beat_s;
    logic              push_s, pop_s;

    assign in_beat_s = {in_index, in_trigger, in_data};
    assign push_s    = in_valid && in_ready_q;
    assign pop_s     = out_valid_q && out_ready;

    // Next occupancy state and main/skid register contents.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (push_s) begin
                    main_d  = in_beat_s;
                    state_d = ONE;
                end else begin
                    state_d = EMPTY;
                end
            end
            ONE: begin
                if (push_s && pop_s) begin
                    main_d  = in_beat_s;
                    state_d = ONE;
                end else if (push_s) begin
                    skid_d  = in_beat_s;
                    state_d = FULL;
                end else if (pop_s) begin
                    state_d = EMPTY;
                end else begin
                    state_d = ONE;
                end
            end
            FULL: begin
                if (pop_s) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Flush only kills occupancy; data registers keep whatever they load.
        if (flush) begin
            state_d = EMPTY;
        end else begin
            state_d = state_d;
        end
    end

    // State, beat storage and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= {BEAT_W{1'b0}};
            skid_q      <= {BEAT_W{1'b0}};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= (state_d != EMPTY);
            in_ready_q  <= (state_d != FULL);
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_index   = main_q[BEAT_W-1 -: IDX_W];
    assign out_trigger = main_q[LANES*DATA_W];
    assign out_data    = main_q[LANES*DATA_W-1:0];

`ifdef SAD_PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where a presented beat is back-pressured.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register; deliberately untouched by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
